// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input framer and its frame banks.
package fft_pkg;

    localparam int SAMPLE_W  = 8;
    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_state_e;

    // Reverse the low log2n bits of idx (decimation-in-time input order).
    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned log2n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < int'(log2n); i++) begin
            r = (r << 1) | ((idx >> i) & 32'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One half of the ping-pong frame buffer: N-sample register file, fill state
// and a full-width parallel read port.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int N      = FFT_N,
    parameter int LOG2N  = FFT_LOG2N
) (
    input  logic                     clk_1,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [LOG2N-1:0]         widx,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic                     clr,
    output bank_state_e              state,
    output logic                     full_nx,
    output logic [N*DATA_W-1:0]      rdata
);

    logic signed [DATA_W-1:0] mem [N];
    logic                     wr_last;

    assign wr_last = we && (widx == LOG2N'(N - 1));

    // Sample storage; data is not reset, only the fill state is.
    always_ff @(posedge clk_1) begin
        if (we) mem[widx] <= wdata;
    end

    // Fill state: clear wins, otherwise a write moves the bank toward FULL.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n)       state <= EMPTY;
        else if (clr)     state <= EMPTY;
        else if (we)      state <= wr_last ? FULL : FILLING;
    end

    // Next-cycle fullness, used by the top to register its handshakes.
    always_comb begin
        full_nx = (state == FULL);
        if (clr)          full_nx = 1'b0;
        else if (wr_last) full_nx = 1'b1;
    end

    for (genvar k = 0; k < N; k++) begin : g_rd
        assign rdata[k*DATA_W +: DATA_W] = mem[k];
    end

endmodule

// File: rtl/fft_input_framer.sv
// Streams signed samples into a ping-pong pair of frame banks and presents
// each complete frame as N parallel lanes to the FFT datapath.
// Build option: define BIT_REVERSE_EN to present lanes in bit-reversed
// (decimation-in-time) order; otherwise lanes are in natural order.
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int N      = FFT_N
) (
    input  logic                     clk_1,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [N*DATA_W-1:0]      m_data,
    output logic                     frame_err,
    output logic [7:0]               frame_cnt
);

    localparam int LOG2N = $clog2(N);

    logic               wr_bank, rd_bank, wr_bank_nx, rd_bank_nx;
    logic [LOG2N-1:0]   wr_idx;
    logic               accept, at_last, short_last, missing_last, wr_en, handoff;
    logic [1:0]         we, clr, full_nx;
    bank_state_e        bank_st [2];
    logic [N*DATA_W-1:0] bank_q [2];
    logic [N*DATA_W-1:0] frame_nat;
    logic [N*DATA_W-1:0] frame_p0, frame_p1;
    logic               vld_p0;

    assign accept       = s_valid && s_ready;
    assign at_last      = (wr_idx == LOG2N'(N - 1));
    assign short_last   = accept && s_last && !at_last;
    assign missing_last = accept && !s_last && at_last;
    assign wr_en        = accept && !short_last;
    assign m_valid      = (bank_st[rd_bank] == FULL);
    assign handoff      = m_valid && m_ready;
    assign wr_bank_nx   = wr_bank ^ (wr_en && at_last);
    assign rd_bank_nx   = rd_bank ^ handoff;
    assign vld_p0       = full_nx[rd_bank_nx];

    // Per-bank write enables and clears (handoff or discarded partial frame).
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            we[b]  = wr_en && (wr_bank == 1'(b));
            clr[b] = (handoff && (rd_bank == 1'(b))) || (short_last && (wr_bank == 1'(b)));
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .DATA_W (DATA_W),
            .N      (N),
            .LOG2N  (LOG2N)
        ) u_bank (
            .clk_1   (clk_1),
            .rst_n   (rst_n),
            .we      (we[b]),
            .widx    (wr_idx),
            .wdata   (s_data),
            .clr     (clr[b]),
            .state   (bank_st[b]),
            .full_nx (full_nx[b]),
            .rdata   (bank_q[b])
        );
    end

    // Frame that will be on the read side next cycle, with write-through of
    // the sample completing it so the lanes are ready with m_valid.
    always_comb begin
        frame_nat = bank_q[rd_bank_nx];
        if (we[rd_bank_nx]) frame_nat[int'(wr_idx)*DATA_W +: DATA_W] = s_data;
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
`ifdef BIT_REVERSE_EN
        localparam int SRC = int'(bitrev(k, LOG2N));
`else
        localparam int SRC = k;
`endif
        assign frame_p0[k*DATA_W +: DATA_W] = frame_nat[SRC*DATA_W +: DATA_W];
    end

    // ---- stage p0 -> p1: pointers, handshakes, error pulse, output lanes ----
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            s_ready   <= 1'b1;
            frame_err <= 1'b0;
            frame_cnt <= 8'd0;
            frame_p1  <= '0;
        end else begin
            wr_bank   <= wr_bank_nx;
            rd_bank   <= rd_bank_nx;
            s_ready   <= !full_nx[wr_bank_nx];
            frame_err <= short_last || missing_last;
            if (handoff) frame_cnt <= frame_cnt + 8'd1;
            if (short_last)  wr_idx <= '0;
            else if (wr_en)  wr_idx <= at_last ? '0 : wr_idx + LOG2N'(1);
            if (vld_p0)      frame_p1 <= frame_p0;
        end
    end

    assign m_data = frame_p1;

    // The read bank is FULL whenever it is handed off, so it cannot be written.
    a_no_handoff_write_collision: assert property (
        @(posedge clk_1) disable iff (!rst_n)
        !(handoff && wr_en && (wr_bank == rd_bank))
    );

endmodule
